// File: rtl/dfq_pkg.sv
// Shared types and constants for the dual-issue fetch queue and its neighbours (decode, HCU).
package dfq_pkg;

  localparam int DFQ_IW = 16;
  localparam int DFQ_AW = 8;

  // One queue entry at the default widths; the ring itself stores the packed {pc, inst} form.
  typedef struct packed {
    logic [DFQ_AW-1:0] pc;
    logic [DFQ_IW-1:0] inst;
  } dfq_entry_t;

  typedef enum logic [2:0] {
    ITYPE_LDR = 3'b011,
    ITYPE_STR = 3'b100
  } inst_type_e;

endpackage

// File: rtl/dfq_ring.sv
// DEPTH-entry circular buffer accepting 0/1/2 pushes and 0/1/2 pops per cycle.
// Exposes the entry count and the two oldest entries combinationally.
module dfq_ring
  import dfq_pkg::*;
#(
  parameter int EW    = DFQ_AW + DFQ_IW,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [1:0]    push_n,
  input  logic [EW-1:0] push0,
  input  logic [EW-1:0] push1,
  input  logic [1:0]    pop_n,
  output logic [CW-1:0] count,
  output logic [EW-1:0] head0,
  output logic [EW-1:0] head1
);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // NOTE: the storage array has no reset; whether an entry is meaningful is carried by count alone.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[tail] <= push0;
    if (push_n == 2'd2) mem[tail + PW'(1)] <= push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign head0 = mem[head];
  assign head1 = mem[head + PW'(1)];

  // The issue rule in the fetch unit reserves space for every outstanding pair, so these never fire.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    clear || (int'(count) + int'(push_n) - int'(pop_n) <= DEPTH));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    clear || (int'(pop_n) <= int'(count)));

endmodule

// File: rtl/dual_fetch_queue.sv
// Fetch stage feeding S0: fetches aligned instruction pairs, buffers them, presents the P0/P1 slots.
// Optional macro DFQ_STARVE_CNT_EN adds a saturating starve_cnt output.
module dual_fetch_queue
  import dfq_pkg::*;
#(
  parameter int             IW        = DFQ_IW,
  parameter int             AW        = DFQ_AW,
  parameter int             DEPTH     = 8,
  parameter int             MAX_OUTST = 2,
  parameter logic [AW-1:0]  RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [2*IW-1:0] imem_rdata,
  input  logic            fetch_next,
  input  logic            flush,
  input  logic [AW-1:0]   flush_pc,
  output logic            dec0_valid,
  output logic [IW-1:0]   dec0_inst,
  output logic [AW-1:0]   dec0_pc,
  output logic            dec1_valid,
  output logic [IW-1:0]   dec1_inst,
  output logic [AW-1:0]   dec1_pc
`ifdef DFQ_STARVE_CNT_EN
  ,
  output logic [15:0]     starve_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + IW;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;      // pair address of the next response that will be kept
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic          skip_low;

  logic [CW-1:0] count;
  logic [EW-1:0] head0;
  logic [EW-1:0] head1;
  logic [EW-1:0] push0;
  logic [EW-1:0] push1;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  logic          req_ok;
  logic          req_fire;
  logic          keep_resp;
  logic [AW-1:0] aligned_pc;

  assign aligned_pc = {fetch_pc[AW-1:1], 1'b0};
  assign imem_addr  = aligned_pc;

  // Only ask for a new pair when the queue can absorb it plus every pair already in flight.
  assign req_ok   = !flush
                 && (int'(outstanding) < MAX_OUTST)
                 && ((DEPTH - int'(count)) >= 2 * (int'(outstanding) + 1));
  assign imem_req = req_ok && rst_n;
  assign req_fire = req_ok && imem_ready;

  assign keep_resp = imem_rvalid && !flush && (discard == '0);

  // NOTE: every signal driven here gets a default first so no latch is inferred on any path.
  always_comb begin
    push_n = 2'd0;
    push0  = '0;
    push1  = '0;
    pop_n  = 2'd0;
    if (keep_resp) begin
      if (skip_low) begin
        push_n = 2'd1;
        push0  = {resp_pc + AW'(1), imem_rdata[2*IW-1:IW]};
      end else begin
        push_n = 2'd2;
        push0  = {resp_pc, imem_rdata[IW-1:0]};
        push1  = {resp_pc + AW'(1), imem_rdata[2*IW-1:IW]};
      end
    end
    if (fetch_next && !flush) begin
      pop_n = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= {RESET_PC[AW-1:1], 1'b0};
      outstanding <= '0;
      discard     <= '0;
      skip_low    <= 1'b0;
    end else begin
      case ({req_fire, imem_rvalid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (flush) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= flush_pc;
        resp_pc  <= {flush_pc[AW-1:1], 1'b0};
        skip_low <= flush_pc[0];
        discard  <= outstanding - OW'(imem_rvalid) + OW'(req_fire);
      end else begin
        if (req_fire) fetch_pc <= aligned_pc + AW'(2);
        if (imem_rvalid && (discard != '0)) discard <= discard - OW'(1);
        if (keep_resp) begin
          resp_pc  <= resp_pc + AW'(2);
          skip_low <= 1'b0;
        end
      end
    end
  end

  dfq_ring #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop_n  (pop_n),
    .count  (count),
    .head0  (head0),
    .head1  (head1)
  );

  // Slots read as zero when empty so stale storage never leaks to decode.
  assign dec0_valid = (count > CW'(0));
  assign dec1_valid = (count > CW'(1));
  assign dec0_inst  = dec0_valid ? head0[IW-1:0]  : '0;
  assign dec0_pc    = dec0_valid ? head0[EW-1:IW] : '0;
  assign dec1_inst  = dec1_valid ? head1[IW-1:0]  : '0;
  assign dec1_pc    = dec1_valid ? head1[EW-1:IW] : '0;

`ifdef DFQ_STARVE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (flush) begin
      starve_cnt <= '0;
    end else if (fetch_next && (count < CW'(2)) && (starve_cnt != 16'hFFFF)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed bench for dual_fetch_queue: streaming, stall fill, flush with in-flight and colliding
// responses, partial pop, and the optional starve counter.
module tb_dual_fetch_queue;

  localparam int IW = 16;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic            imem_ready = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [2*IW-1:0] imem_rdata = '0;
  logic            fetch_next = 1'b0;
  logic            flush = 1'b0;
  logic [AW-1:0]   flush_pc = '0;
  logic            dec0_valid;
  logic [IW-1:0]   dec0_inst;
  logic [AW-1:0]   dec0_pc;
  logic            dec1_valid;
  logic [IW-1:0]   dec1_inst;
  logic [AW-1:0]   dec1_pc;
`ifdef DFQ_STARVE_CNT_EN
  logic [15:0]     starve_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] pend[$];
  bit auto_resp = 1'b0;

  always #5 clk = ~clk;

  dual_fetch_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fetch_next  (fetch_next),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .dec0_valid  (dec0_valid),
    .dec0_inst   (dec0_inst),
    .dec0_pc     (dec0_pc),
    .dec1_valid  (dec1_valid),
    .dec1_inst   (dec1_inst),
    .dec1_pc     (dec1_pc)
`ifdef DFQ_STARVE_CNT_EN
    ,
    .starve_cnt  (starve_cnt)
`endif
  );

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] p);
    return {8'hA5, p};
  endfunction

  // One clock: record accepted requests, optionally answer the oldest one, return at the negedge.
  task automatic tick();
    bit            fired;
    logic [AW-1:0] a;
    #1;
    fired = imem_req && imem_ready;
    a     = imem_addr;
    @(posedge clk);
    if (fired) pend.push_back(a);
    #1;
    if (auto_resp && pend.size() > 0) begin
      a           = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = {inst_of(a + 8'd1), inst_of(a)};
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
  endtask

  // Present the response to the oldest accepted request during the next cycle.
  task automatic deliver();
    logic [AW-1:0] a;
    checks++;
    if (pend.size() == 0) begin
      errors++;
      $display("FAIL deliver: pending requests=0 required>0");
      imem_rvalid = 1'b0;
    end else begin
      a           = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = {inst_of(a + 8'd1), inst_of(a)};
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    fetch_next  = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    auto_resp   = 1'b0;
    pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
    checks++;
    if (imem_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
    checks++;
    if ({dec0_valid, dec0_inst, dec0_pc, dec1_valid, dec1_inst, dec1_pc} !== '0) begin
      errors++;
      $display("FAIL reset_dec: got v0=%0b i0=%0h p0=%0h v1=%0b i1=%0h p1=%0h expected all 0",
               dec0_valid, dec0_inst, dec0_pc, dec1_valid, dec1_inst, dec1_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    auto_resp  = 1'b1;
    imem_ready = 1'b1;
    fetch_next = 1'b1;
    for (int n = 0; n < 7; n++) begin
      checks++;
      if (imem_addr !== AW'(2 * n)) begin
        errors++; $display("FAIL stream_addr[%0d]: got %0h expected %0h", n, imem_addr, 2 * n);
      end
      if (n < 2) begin
        checks++;
        if (dec0_valid !== 1'b0) begin
          errors++; $display("FAIL stream_empty[%0d]: dec0_valid got %0b expected 0", n, dec0_valid);
        end
      end else begin
        checks++;
        if (!(dec0_valid && dec1_valid) || dec0_pc !== AW'(2 * (n - 2)) || dec1_pc !== AW'(2 * (n - 2) + 1)) begin
          errors++;
          $display("FAIL stream_pair[%0d]: got v=%0b%0b pc=%0h/%0h expected v=11 pc=%0h/%0h",
                   n, dec0_valid, dec1_valid, dec0_pc, dec1_pc, 2 * (n - 2), 2 * (n - 2) + 1);
        end
        checks++;
        if (dec1_inst !== inst_of(AW'(2 * (n - 2) + 1))) begin
          errors++; $display("FAIL stream_inst[%0d]: got %0h expected %0h", n, dec1_inst, inst_of(AW'(2 * (n - 2) + 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    auto_resp  = 1'b1;
    imem_ready = 1'b1;
    fetch_next = 1'b0;
    repeat (5) tick();
    checks++;
    if (dec0_pc !== 8'd0 || dec1_pc !== 8'd1) begin
      errors++; $display("FAIL stall_hold_mid: got %0h/%0h expected 0/1", dec0_pc, dec1_pc);
    end
    repeat (5) tick();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full: got %0b expected 0", imem_req); end
    checks++;
    if (!(dec0_valid && dec1_valid) || dec0_pc !== 8'd0 || dec1_pc !== 8'd1) begin
      errors++; $display("FAIL stall_hold: got v=%0b%0b pc=%0h/%0h expected v=11 pc=0/1",
                         dec0_valid, dec1_valid, dec0_pc, dec1_pc);
    end
    // Draining shows all eight buffered entries 0..7 followed by the refill pair 8/9.
    fetch_next = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (!(dec0_valid && dec1_valid) || dec0_pc !== AW'(2 * k) || dec1_pc !== AW'(2 * k + 1)) begin
        errors++; $display("FAIL stall_drain[%0d]: got pc=%0h/%0h expected %0h/%0h",
                           k, dec0_pc, dec1_pc, 2 * k, 2 * k + 1);
      end
    end
  endtask

  task automatic test_flush_outstanding();
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL outst_limit: got req=%0b expected 0", imem_req); end
    flush    = 1'b1;
    flush_pc = 8'd5;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL flush_req_forced: got %0b expected 0", imem_req); end
    tick();
    flush = 1'b0;
    checks++;
    if (imem_addr !== 8'd4) begin errors++; $display("FAIL flush_addr: got %0h expected 4", imem_addr); end
    for (int s = 0; s < 2; s++) begin
      deliver();
      tick();
      checks++;
      if (dec0_valid !== 1'b0) begin
        errors++; $display("FAIL flush_stale_drop[%0d]: dec0_valid got %0b expected 0 (pc=%0h)", s, dec0_valid, dec0_pc);
      end
    end
    deliver();
    tick();
    checks++;
    if (dec0_valid !== 1'b1 || dec0_pc !== 8'd5 || dec0_inst !== inst_of(8'd5) || dec1_valid !== 1'b0) begin
      errors++; $display("FAIL flush_skip_low: got v=%0b%0b pc0=%0h inst0=%0h expected v=10 pc0=5 inst0=%0h",
                         dec0_valid, dec1_valid, dec0_pc, dec0_inst, inst_of(8'd5));
    end
    deliver();
    tick();
    checks++;
    if (!(dec0_valid && dec1_valid) || dec0_pc !== 8'd5 || dec1_pc !== 8'd6) begin
      errors++; $display("FAIL flush_next_pair: got v=%0b%0b pc=%0h/%0h expected v=11 pc=5/6",
                         dec0_valid, dec1_valid, dec0_pc, dec1_pc);
    end
  endtask

  task automatic test_flush_collision();
    do_reset();
    imem_ready = 1'b1;
    tick();
    deliver();
    tick();
    checks++;
    if (dec0_pc !== 8'd0 || dec1_pc !== 8'd1 || !dec1_valid) begin
      errors++; $display("FAIL coll_setup: got pc=%0h/%0h v1=%0b expected 0/1 v1=1", dec0_pc, dec1_pc, dec1_valid);
    end
    flush      = 1'b1;
    flush_pc   = 8'hFE;
    fetch_next = 1'b1;
    deliver();
    tick();
    flush      = 1'b0;
    fetch_next = 1'b0;
    checks++;
    if (dec0_valid !== 1'b0 || dec1_valid !== 1'b0) begin
      errors++; $display("FAIL coll_empty: got v=%0b%0b expected v=00", dec0_valid, dec1_valid);
    end
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'hFE) begin
      errors++; $display("FAIL coll_redirect: got req=%0b addr=%0h expected req=1 addr=fe", imem_req, imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %0h expected 0", imem_addr); end
    deliver();
    tick();
    checks++;
    if (!(dec0_valid && dec1_valid) || dec0_pc !== 8'hFE || dec1_pc !== 8'hFF) begin
      errors++; $display("FAIL coll_kept: got v=%0b%0b pc=%0h/%0h expected v=11 pc=fe/ff",
                         dec0_valid, dec1_valid, dec0_pc, dec1_pc);
    end
  endtask

  task automatic test_partial_pop();
    do_reset();
    imem_ready = 1'b1;
    flush      = 1'b1;
    flush_pc   = 8'd7;
    tick();
    flush = 1'b0;
    checks++;
    if (imem_addr !== 8'd6) begin errors++; $display("FAIL odd_target_addr: got %0h expected 6", imem_addr); end
    tick();
    deliver();
    tick();
    checks++;
    if (dec0_valid !== 1'b1 || dec0_pc !== 8'd7 || dec1_valid !== 1'b0 || dec1_pc !== 8'd0 || dec1_inst !== 16'd0) begin
      errors++; $display("FAIL count1: got v=%0b%0b pc=%0h/%0h inst1=%0h expected v=10 pc=7/0 inst1=0",
                         dec0_valid, dec1_valid, dec0_pc, dec1_pc, dec1_inst);
    end
    fetch_next = 1'b1;
    deliver();
    tick();
    fetch_next = 1'b0;
    checks++;
    if (!(dec0_valid && dec1_valid) || dec0_pc !== 8'd8 || dec1_pc !== 8'd9) begin
      errors++; $display("FAIL pop_push: got v=%0b%0b pc=%0h/%0h expected v=11 pc=8/9",
                         dec0_valid, dec1_valid, dec0_pc, dec1_pc);
    end
  endtask

`ifdef DFQ_STARVE_CNT_EN
  task automatic test_starve();
    do_reset();
    imem_ready = 1'b0;
    fetch_next = 1'b1;
    checks++;
    if (starve_cnt !== 16'd0) begin errors++; $display("FAIL starve_reset: got %0d expected 0", starve_cnt); end
    repeat (6) tick();
    checks++;
    if (starve_cnt !== 16'd6) begin errors++; $display("FAIL starve_count: got %0d expected 6", starve_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (starve_cnt !== 16'd0) begin errors++; $display("FAIL starve_flush: got %0d expected 0", starve_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_outstanding();
    test_flush_collision();
    test_partial_pop();
`ifdef DFQ_STARVE_CNT_EN
    test_starve();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
